lfsr_decrypt: RTL and testbench
===============================

Name: lfsr_decrypt

Overview:
- Decrypter for the 6-bit LFSR scrambler.
- Reads the scrambled stream (preamble plus message) from dat_mem, recovers the LFSR start state from the known preamble character, and identifies the tap pattern from a fixed 6-entry table.
- Writes the de-scrambled message, preamble stripped, back into dat_mem.
- Drives the existing dat_mem port directly: combinational read, write on the clock edge.

Parameters:
- MSG_BASE, 8'd64: dat_mem address of scrambled byte 0.
- OUT_BASE, 8'd0: dat_mem address of first decrypted output byte.
- MSG_LEN, 64: total scrambled bytes processed (preamble + message).
- PRE_MIN, 7: guaranteed minimum preamble length; number of bytes used for tap identification.
- PRE_CHAR, 8'h5F: preamble plaintext character '_'.

Ports:
- clk, input, 1: clock, rising edge.
- init_n, input, 1: asynchronous active-low reset.
- start, input, 1: begin decryption; sampled only in IDLE.
- raddr, output, 8: dat_mem read address.
- data_out, input, 8: dat_mem read data (combinational from raddr).
- waddr, output, 8: dat_mem write address.
- data_in, output, 8: dat_mem write data.
- write_en, output, 1: dat_mem write enable.
- busy, output, 1: high in any state other than IDLE/DONE.
- done, output, 1: high in DONE until next accepted start.
- err, output, 1: no tap candidate matched; valid while done=1.
- tap_idx, output, 3: selected tap table index 0..5; valid while done=1 and err=0.

Behaviour:
- Reset (init_n low, asynchronous): state IDLE; write_en=0, busy=0, done=0, err=0, tap_idx=0, raddr=0, waddr=0, data_in=0, counters 0. Reset mid-operation aborts immediately; partial output is left in memory.
- Tap table: 0:6'h21, 1:6'h2D, 2:6'h30, 3:6'h33, 4:6'h36, 5:6'h39.
- LFSR step rule, identical to lfsr6: s_next = {s[4:0], ^(s & taps)}.
- Scrambled byte i = plaintext_i ^ {2'b00, s_i}, with s_0 = start state. All comparisons use the full 8 bits.
- IDLE: start=1 goes to SEED; done and err clear on that edge.
  - start while busy or in DONE-before-accept: DONE accepts start (re-run); busy states ignore it.
- SEED (1 cycle):
  - raddr=MSG_BASE.
  - seed = data_out[5:0] ^ PRE_CHAR[5:0].
  - All 6 candidate LFSRs load seed; valid mask = 6'b111111.
  - If data_out[7:6] != PRE_CHAR[7:6], mask = 0.
- CHECK (PRE_MIN-1 cycles, k = 1..PRE_MIN-1):
  - raddr=MSG_BASE+k.
  - Each candidate c advances one step before comparing, i.e. it uses s_k.
  - Clear valid[c] if data_out != {2'b00, s_k(c)} ^ PRE_CHAR.
- SELECT (1 cycle):
  - tap_idx = lowest set index of the mask.
  - Mask all zero: err=1, go to DONE with no writes.
  - Otherwise reload the working LFSR with seed and the selected taps; i=0, j=0, strip=1.
- DECODE (MSG_LEN cycles, i = 0..MSG_LEN-1):
  - raddr=MSG_BASE+i; d = data_out ^ {2'b00, s_i}; LFSR advances every cycle.
  - If strip=1 and d==PRE_CHAR: no write.
  - Else: strip=0, write_en=1, waddr=OUT_BASE+j, data_in=d, j++.
  - Once strip clears, later PRE_CHAR bytes are written.
  - All address arithmetic is 8-bit, wrap-around.
- DONE: busy=0, done=1; write_en=0 outside DECODE/PAD.
- Latency without padding: done rises PRE_MIN+MSG_LEN+1 edges after the edge that sampled start (72 with defaults).
- Error path: done rises PRE_MIN+1 edges after start.

Optional Feature:
- Macro: LFSR_DECRYPT_SPACE_PAD_EN.
- Defined: after DECODE, state PAD writes 8'h20 at OUT_BASE+j for j up to MSG_LEN-1, one per cycle with write_en=1. This adds (stripped count) cycles before DONE. Output region is always exactly MSG_LEN bytes.
- Undefined: DECODE goes directly to DONE; memory beyond the last message byte is untouched.

Test Plan:
- Scramble "Hello World" padded to 57 chars with 7-char preamble, taps 6'h21, start 6'h01, stored at mem[64..127]; pulse start. Required: mem[0..56] = message, write_en pulses 57 times, done after 72 cycles, err=0, tap_idx=0.
- Preamble length 12, taps 6'h39, start 6'h2A. Required: tap_idx=5, exactly 52 writes starting at mem[0]; PAD build additionally has mem[52..63]=8'h20.
- Message containing '_' at positions 3 and 10 after the preamble. Required: both underscores appear at mem[3] and mem[10]; only the leading preamble is stripped.
- mem[64..127] filled with 8'hFF. Required: err=1, done at cycle 8, write_en never asserted, tap_idx don't-care.
- Drop init_n low during DECODE cycle 20. Required: write_en=0, busy=0, done=0 immediately without a clock edge. Release reset and pulse start: a full correct run follows.
- Assert start continuously during a run. Required: no restart mid-run. Start held into DONE triggers exactly one re-run with identical memory result.

Source files
------------

// File: rtl/lfsr_decrypt.sv
// rtl/lfsr_decrypt.sv - 6-bit LFSR descrambler: seed/tap recovery from preamble, in-place message write-back.
// Optional trailing space padding of the output region: LFSR_DECRYPT_SPACE_PAD_EN.
module lfsr_decrypt #(
  parameter logic [7:0] MSG_BASE = 8'd64,
  parameter logic [7:0] OUT_BASE = 8'd0,
  parameter int         MSG_LEN  = 64,
  parameter int         PRE_MIN  = 7,
  parameter logic [7:0] PRE_CHAR = 8'h5F
) (
  input  logic       clk,
  input  logic       init_n,
  input  logic       start,
  output logic [7:0] raddr,
  input  logic [7:0] data_out,
  output logic [7:0] waddr,
  output logic [7:0] data_in,
  output logic       write_en,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] tap_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_CHECK, S_SELECT, S_DECODE, S_PAD, S_DONE
  } state_t;

`ifdef LFSR_DECRYPT_SPACE_PAD_EN
  localparam int JW = 9;
  localparam logic [8:0] OUT_LEN = 9'(MSG_LEN);
`else
  localparam int JW = 8;
`endif
  typedef logic [JW-1:0] j_t;

  localparam logic [7:0] CHECK_LAST  = 8'(PRE_MIN - 1);
  localparam logic [7:0] DECODE_LAST = 8'(MSG_LEN - 1);

  function automatic logic [5:0] tap_of(input logic [2:0] idx);
    case (idx)
      3'd0:    tap_of = 6'h21;
      3'd1:    tap_of = 6'h2D;
      3'd2:    tap_of = 6'h30;
      3'd3:    tap_of = 6'h33;
      3'd4:    tap_of = 6'h36;
      3'd5:    tap_of = 6'h39;
      default: tap_of = 6'h21;
    endcase
  endfunction

  function automatic logic [5:0] lfsr_step(input logic [5:0] s, input logic [5:0] taps);
    lfsr_step = {s[4:0], ^(s & taps)};
  endfunction

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  j_t         j_q, j_d;
  logic       strip_q, strip_d;
  logic [5:0] seed_q, seed_d;
  logic [5:0] cand_q [6];
  logic [5:0] cand_d [6];
  logic [5:0] mask_q, mask_d;
  logic [5:0] lfsr_q, lfsr_d;
  logic [2:0] tap_idx_q, tap_idx_d;
  logic       err_q, err_d;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      j_q       <= '0;
      strip_q   <= 1'b0;
      seed_q    <= '0;
      for (int c = 0; c < 6; c++) cand_q[c] <= '0;
      mask_q    <= '0;
      lfsr_q    <= '0;
      tap_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      j_q       <= j_d;
      strip_q   <= strip_d;
      seed_q    <= seed_d;
      for (int c = 0; c < 6; c++) cand_q[c] <= cand_d[c];
      mask_q    <= mask_d;
      lfsr_q    <= lfsr_d;
      tap_idx_q <= tap_idx_d;
      err_q     <= err_d;
    end
  end

  logic [5:0] nxt;
  logic [7:0] dec;
  logic [2:0] sel;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    j_d       = j_q;
    strip_d   = strip_q;
    seed_d    = seed_q;
    cand_d    = cand_q;
    mask_d    = mask_q;
    lfsr_d    = lfsr_q;
    tap_idx_d = tap_idx_q;
    err_d     = err_q;
    raddr     = '0;
    waddr     = '0;
    data_in   = '0;
    write_en  = 1'b0;
    nxt       = '0;
    dec       = '0;
    sel       = '0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SEED;
          err_d   = 1'b0;
        end
      end

      S_SEED: begin
        raddr  = MSG_BASE;
        seed_d = data_out[5:0] ^ PRE_CHAR[5:0];
        for (int c = 0; c < 6; c++) cand_d[c] = seed_d;
        // Upper two bits are never scrambled, so a mismatch there rules out every candidate.
        mask_d  = (data_out[7:6] == PRE_CHAR[7:6]) ? 6'h3F : 6'h00;
        cnt_d   = 8'd1;
        state_d = S_CHECK;
      end

      S_CHECK: begin
        raddr = MSG_BASE + cnt_q;
        for (int c = 0; c < 6; c++) begin
          nxt       = lfsr_step(cand_q[c], tap_of(3'(c)));
          cand_d[c] = nxt;
          if (data_out != ({2'b00, nxt} ^ PRE_CHAR)) mask_d[c] = 1'b0;
        end
        if (cnt_q == CHECK_LAST) state_d = S_SELECT;
        else                     cnt_d   = cnt_q + 8'd1;
      end

      S_SELECT: begin
        for (int c = 5; c >= 0; c--) begin
          if (mask_q[c]) sel = 3'(c);
        end
        if (mask_q == 6'h00) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tap_idx_d = sel;
          lfsr_d    = seed_q;
          cnt_d     = '0;
          j_d       = '0;
          strip_d   = 1'b1;
          state_d   = S_DECODE;
        end
      end

      S_DECODE: begin
        raddr  = MSG_BASE + cnt_q;
        dec    = data_out ^ {2'b00, lfsr_q};
        lfsr_d = lfsr_step(lfsr_q, tap_of(tap_idx_q));
        if (!(strip_q && dec == PRE_CHAR)) begin
          strip_d  = 1'b0;
          write_en = 1'b1;
          waddr    = OUT_BASE + j_q[7:0];
          data_in  = dec;
          j_d      = j_q + j_t'(1);
        end
        if (cnt_q == DECODE_LAST) begin
`ifdef LFSR_DECRYPT_SPACE_PAD_EN
          state_d = (j_d < OUT_LEN) ? S_PAD : S_DONE;
`else
          state_d = S_DONE;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

`ifdef LFSR_DECRYPT_SPACE_PAD_EN
      S_PAD: begin
        write_en = 1'b1;
        waddr    = OUT_BASE + j_q[7:0];
        data_in  = 8'h20;
        j_d      = j_q + j_t'(1);
        if (j_d >= OUT_LEN) state_d = S_DONE;
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done    = (state_q == S_DONE);
  assign err     = err_q;
  assign tap_idx = tap_idx_q;

endmodule

// File: tb/tb_lfsr_decrypt.sv
// tb/tb_lfsr_decrypt.sv - directed self-checking bench for lfsr_decrypt with a behavioural dat_mem.
module tb_lfsr_decrypt;

  logic       clk = 1'b0;
  logic       init_n;
  logic       start;
  logic [7:0] raddr, data_out, waddr, data_in;
  logic       write_en, busy, done, err;
  logic [2:0] tap_idx;

  logic [7:0] mem [256];
  logic [7:0] plain [64];
  int         wr_cnt = 0;
  int         checks = 0;
  int         errors = 0;

`ifdef LFSR_DECRYPT_SPACE_PAD_EN
  localparam bit PAD = 1'b1;
  localparam logic [7:0] FILLV = 8'h20;
`else
  localparam bit PAD = 1'b0;
  localparam logic [7:0] FILLV = 8'hEE;
`endif

  lfsr_decrypt dut (
    .clk      (clk),
    .init_n   (init_n),
    .start    (start),
    .raddr    (raddr),
    .data_out (data_out),
    .waddr    (waddr),
    .data_in  (data_in),
    .write_en (write_en),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .tap_idx  (tap_idx)
  );

  always #5 clk = ~clk;

  assign data_out = mem[raddr];

  always @(posedge clk) begin
    if (write_en) begin
      mem[waddr] <= data_in;
      wr_cnt     <= wr_cnt + 1;
    end
  end

  function automatic logic [7:0] exp_out(input int j, input int pre);
    if (j < 64 - pre) exp_out = plain[pre + j];
    else              exp_out = FILLV;
  endfunction

  task automatic load_stream(input logic [5:0] taps, input logic [5:0] st);
    logic [5:0] s;
    s = st;
    for (int i = 0; i < 64; i++) begin
      mem[64 + i] <= plain[i] ^ {2'b00, s};
      s = {s[4:0], ^(s & taps)};
    end
    for (int i = 0; i < 64; i++) mem[i] <= 8'hEE;
  endtask

  task automatic run_to_done(output int cycles);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cycles = 0;
    while (done !== 1'b1 && cycles < 400) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic set_hello();
    string hw;
    hw = "Hello World";
    for (int i = 0; i < 64; i++) plain[i] = (i < 7) ? 8'h5F : 8'h20;
    for (int i = 0; i < hw.len(); i++) plain[7 + i] = hw[i];
  endtask

  task automatic test_reset();
    init_n = 1'b1;
    start  = 1'b0;
    #1 init_n = 1'b0;
    #2;
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (err !== 1'b0)      begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL reset_write_en: got %b expected 0", write_en); end
    checks++; if (tap_idx !== 3'd0)  begin errors++; $display("FAIL reset_tap_idx: got %0d expected 0", tap_idx); end
    checks++; if (raddr !== 8'd0)    begin errors++; $display("FAIL reset_raddr: got %0h expected 0", raddr); end
    checks++; if (waddr !== 8'd0 || data_in !== 8'd0) begin errors++; $display("FAIL reset_wport: got %0h/%0h expected 0/0", waddr, data_in); end
    @(negedge clk);
    init_n = 1'b1;
  endtask

  task automatic test_hello();
    int cyc, w0;
    set_hello();
    load_stream(6'h21, 6'h01);
    w0 = wr_cnt;
    run_to_done(cyc);
    checks++; if (cyc != (PAD ? 79 : 72)) begin errors++; $display("FAIL hello_latency: got %0d expected %0d", cyc, PAD ? 79 : 72); end
    checks++; if (err !== 1'b0)     begin errors++; $display("FAIL hello_err: got %b expected 0", err); end
    checks++; if (tap_idx !== 3'd0) begin errors++; $display("FAIL hello_tap_idx: got %0d expected 0", tap_idx); end
    checks++; if (wr_cnt - w0 != (PAD ? 64 : 57)) begin errors++; $display("FAIL hello_writes: got %0d expected %0d", wr_cnt - w0, PAD ? 64 : 57); end
    for (int j = 0; j < 64; j++) begin
      checks++;
      if (mem[j] !== exp_out(j, 7)) begin errors++; $display("FAIL hello_mem[%0d]: got %0h expected %0h", j, mem[j], exp_out(j, 7)); end
    end
  endtask

  task automatic test_taps5();
    int cyc, w0;
    for (int i = 0; i < 64; i++) plain[i] = (i < 12) ? 8'h5F : 8'(8'h41 + (i - 12) % 26);
    load_stream(6'h39, 6'h2A);
    w0 = wr_cnt;
    run_to_done(cyc);
    checks++; if (tap_idx !== 3'd5) begin errors++; $display("FAIL taps5_tap_idx: got %0d expected 5", tap_idx); end
    checks++; if (err !== 1'b0)     begin errors++; $display("FAIL taps5_err: got %b expected 0", err); end
    checks++; if (cyc != (PAD ? 84 : 72)) begin errors++; $display("FAIL taps5_latency: got %0d expected %0d", cyc, PAD ? 84 : 72); end
    checks++; if (wr_cnt - w0 != (PAD ? 64 : 52)) begin errors++; $display("FAIL taps5_writes: got %0d expected %0d", wr_cnt - w0, PAD ? 64 : 52); end
    for (int j = 0; j < 64; j++) begin
      checks++;
      if (mem[j] !== exp_out(j, 12)) begin errors++; $display("FAIL taps5_mem[%0d]: got %0h expected %0h", j, mem[j], exp_out(j, 12)); end
    end
  endtask

  task automatic test_underscore();
    int cyc;
    for (int i = 0; i < 64; i++) plain[i] = (i < 7) ? 8'h5F : 8'(8'h61 + (i - 7) % 26);
    plain[10] = 8'h5F;
    plain[17] = 8'h5F;
    load_stream(6'h21, 6'h01);
    run_to_done(cyc);
    checks++; if (mem[3] !== 8'h5F)  begin errors++; $display("FAIL under_mem3: got %0h expected 5f", mem[3]); end
    checks++; if (mem[10] !== 8'h5F) begin errors++; $display("FAIL under_mem10: got %0h expected 5f", mem[10]); end
    checks++; if (mem[0] !== 8'h61)  begin errors++; $display("FAIL under_mem0: got %0h expected 61", mem[0]); end
    for (int j = 0; j < 64; j++) begin
      checks++;
      if (mem[j] !== exp_out(j, 7)) begin errors++; $display("FAIL under_mem[%0d]: got %0h expected %0h", j, mem[j], exp_out(j, 7)); end
    end
  endtask

  task automatic test_error();
    int cyc, w0;
    for (int i = 0; i < 64; i++) begin
      mem[64 + i] <= 8'hFF;
      mem[i]      <= 8'hEE;
    end
    w0 = wr_cnt;
    run_to_done(cyc);
    checks++; if (cyc != 8)      begin errors++; $display("FAIL error_latency: got %0d expected 8", cyc); end
    checks++; if (err !== 1'b1)  begin errors++; $display("FAIL error_err: got %b expected 1", err); end
    checks++; if (wr_cnt != w0)  begin errors++; $display("FAIL error_writes: got %0d expected 0", wr_cnt - w0); end
    checks++; if (mem[0] !== 8'hEE || mem[63] !== 8'hEE) begin errors++; $display("FAIL error_mem: got %0h/%0h expected ee/ee", mem[0], mem[63]); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    set_hello();
    load_stream(6'h21, 6'h01);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (28) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || write_en !== 1'b1) begin errors++; $display("FAIL mid_pre_reset: got busy=%b we=%b expected 1/1", busy, write_en); end
    #2 init_n = 1'b0;
    #1;
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL mid_write_en: got %b expected 0", write_en); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL mid_done: got %b expected 0", done); end
    checks++; if (tap_idx !== 3'd0 || raddr !== 8'd0) begin errors++; $display("FAIL mid_regs: got tap=%0d raddr=%0h expected 0/0", tap_idx, raddr); end
    @(negedge clk);
    init_n = 1'b1;
    load_stream(6'h21, 6'h01);
    run_to_done(cyc);
    checks++; if (cyc != (PAD ? 79 : 72)) begin errors++; $display("FAIL mid_rerun_latency: got %0d expected %0d", cyc, PAD ? 79 : 72); end
    for (int j = 0; j < 64; j++) begin
      checks++;
      if (mem[j] !== exp_out(j, 7)) begin errors++; $display("FAIL mid_mem[%0d]: got %0h expected %0h", j, mem[j], exp_out(j, 7)); end
    end
  endtask

  task automatic test_start_held();
    int c1, c2, w0;
    set_hello();
    load_stream(6'h21, 6'h01);
    w0 = wr_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    c1 = 0;
    while (done !== 1'b1 && c1 < 400) begin
      @(posedge clk);
      #1;
      c1++;
    end
    checks++; if (c1 != (PAD ? 79 : 72)) begin errors++; $display("FAIL held_first_latency: got %0d expected %0d", c1, PAD ? 79 : 72); end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL held_rerun: got done=%b busy=%b expected 0/1", done, busy); end
    start = 1'b0;
    c2 = 0;
    while (done !== 1'b1 && c2 < 400) begin
      @(posedge clk);
      #1;
      c2++;
    end
    checks++; if (c2 != (PAD ? 79 : 72)) begin errors++; $display("FAIL held_second_latency: got %0d expected %0d", c2, PAD ? 79 : 72); end
    checks++; if (wr_cnt - w0 != (PAD ? 128 : 114)) begin errors++; $display("FAIL held_writes: got %0d expected %0d", wr_cnt - w0, PAD ? 128 : 114); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL held_settled: got done=%b busy=%b expected 1/0", done, busy); end
    for (int j = 0; j < 64; j++) begin
      checks++;
      if (mem[j] !== exp_out(j, 7)) begin errors++; $display("FAIL held_mem[%0d]: got %0h expected %0h", j, mem[j], exp_out(j, 7)); end
    end
  endtask

  initial begin
    test_reset();
    test_hello();
    test_taps5();
    test_underscore();
    test_error();
    test_reset_mid();
    test_start_held();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
